// File: rtl/arm_multicycle_ctrl.sv
// arm_multicycle_ctrl: multicycle Moore control FSM for the ARM-subset datapath
// Ports:
//   clk, reset (async, active-low)  clock and reset
//   Cond/Op/Funct/Rd                instruction fields from the instruction register
//   ALUFlags                        {N,Z,C,V} from the ALU, captured when leaving EXER/EXEI
//   MemReady                        unified-memory access completes this cycle
//   PCWrite..LinkWrite              datapath mux selects and write strobes
//   Flags                           architectural NZCV register
//   State                           FSM state code (debug)
module arm_multicycle_ctrl #(
  parameter bit FULL_COND = 1'b1,
  parameter bit BL_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       RegWrite,
  output logic       LinkWrite,
  output logic [3:0] Flags,
  output logic [3:0] State
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXER   = 4'd6,
    EXEI   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;
  state_t state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic n, z, c, v, cond_all, cond_ex;
  logic dp_ok, dp_arith, no_write;
  logic [1:0] dp_ctl;
  assign {n, z, c, v} = flags_q;
  assign Flags = flags_q;
  assign State = state_q;
  always_comb begin
    case (Cond)
      4'h0: cond_all = z;
      4'h1: cond_all = ~z;
      4'h2: cond_all = c;
      4'h3: cond_all = ~c;
      4'h4: cond_all = n;
      4'h5: cond_all = ~n;
      4'h6: cond_all = v;
      4'h7: cond_all = ~v;
      4'h8: cond_all = c & ~z;
      4'h9: cond_all = ~c | z;
      4'hA: cond_all = n == v;
      4'hB: cond_all = n != v;
      4'hC: cond_all = ~z & (n == v);
      4'hD: cond_all = z | (n != v);
      4'hE: cond_all = 1'b1;
      default: cond_all = 1'b0;
    endcase
    cond_ex = FULL_COND ? cond_all :
              (Cond == 4'h0) ? z : (Cond == 4'h1) ? ~z : (Cond == 4'hE);
  end
  // dp_arith marks the ops whose C/V are meaningful; logic ops leave C/V untouched
  always_comb begin
    dp_ok    = 1'b1;
    dp_arith = 1'b0;
    no_write = 1'b0;
    dp_ctl   = 2'b00;
    case (Funct[4:1])
      4'b0100: dp_arith = 1'b1;
      4'b0010: begin dp_ctl = 2'b01; dp_arith = 1'b1; end
      4'b0000: dp_ctl = 2'b10;
      4'b1100: dp_ctl = 2'b11;
      4'b1010: begin dp_ctl = 2'b01; dp_arith = 1'b1; no_write = 1'b1; end
      default: dp_ok = 1'b0;
    endcase
  end
  always_comb begin
    state_d    = FETCH;
    flags_d    = flags_q;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    ImmSrc     = Op;
    RegSrc     = {Op == 2'b01 & ~Funct[0], Op == 2'b10};
    RegWrite   = 1'b0;
    LinkWrite  = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        state_d   = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_d   = (Op == 2'b01) ? MEMADR :
                    (Op == 2'b10) ? BRANCH :
                    (Op == 2'b00 && dp_ok) ? (Funct[5] ? EXEI : EXER) : FETCH;
      end
      MEMADR: begin
        ALUSrcB    = 2'b01;
        ALUControl = Funct[3] ? 2'b00 : 2'b01;
        state_d    = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = MemReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = cond_ex;
        PCWrite   = cond_ex & (Rd == 4'd15);
      end
      MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex;
        state_d  = (cond_ex & ~MemReady) ? MEMWR : FETCH;
      end
      EXER, EXEI: begin
        ALUSrcB    = (state_q == EXEI) ? 2'b01 : 2'b00;
        ALUControl = dp_ctl;
        state_d    = ALUWB;
        if (Funct[0] & cond_ex)
          flags_d = {ALUFlags[3:2], dp_arith ? ALUFlags[1:0] : flags_q[1:0]};
      end
      ALUWB: begin
        RegWrite = cond_ex & ~no_write;
        PCWrite  = cond_ex & ~no_write & (Rd == 4'd15);
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = cond_ex;
        LinkWrite = cond_ex & Funct[4] & BL_EN;
      end
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end
endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// tb_arm_multicycle_ctrl: directed-vector bench for full and legacy controller configurations
module tb_arm_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset, MemReady;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite, LinkWrite;
  logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0] Flags, State;
  logic l_PCWrite, l_AdrSrc, l_MemWrite, l_IRWrite, l_ALUSrcA, l_RegWrite, l_LinkWrite;
  logic [1:0] l_ResultSrc, l_ALUSrcB, l_ALUControl, l_ImmSrc, l_RegSrc;
  logic [3:0] l_Flags, l_State;
  int nvec = 0;
  int nmis = 0;
  arm_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .RegWrite(RegWrite), .LinkWrite(LinkWrite), .Flags(Flags), .State(State)
  );
  arm_multicycle_ctrl #(.FULL_COND(1'b0), .BL_EN(1'b0)) dut_l (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .MemReady(MemReady), .PCWrite(l_PCWrite), .AdrSrc(l_AdrSrc),
    .MemWrite(l_MemWrite), .IRWrite(l_IRWrite), .ResultSrc(l_ResultSrc), .ALUSrcA(l_ALUSrcA),
    .ALUSrcB(l_ALUSrcB), .ALUControl(l_ALUControl), .ImmSrc(l_ImmSrc), .RegSrc(l_RegSrc),
    .RegWrite(l_RegWrite), .LinkWrite(l_LinkWrite), .Flags(l_Flags), .State(l_State)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f, input logic [3:0] r);
    Cond = c;
    Op = o;
    Funct = f;
    Rd = r;
  endtask
  task automatic fd;
    MemReady = 1'b1;
    #1;
    chk("fetch_state", 8'(State), 8'd0);
    chk("fetch_irw_pcw", 8'({IRWrite, PCWrite}), 8'b11);
    nxt;
    chk("decode_state", 8'(State), 8'd1);
  endtask
  task automatic exe(input logic [3:0] c, input logic [5:0] f, input logic [3:0] fl);
    instr(c, 2'b00, f, 4'd0);
    ALUFlags = fl;
    fd;
    nxt;
    nxt;
    nxt;
  endtask
  initial begin
    reset = 1'b0;
    MemReady = 1'b0;
    ALUFlags = 4'b0000;
    instr(4'hE, 2'b00, 6'b000000, 4'd0);
    #3;
    chk("rst_state", 8'(State), 8'd0);
    chk("rst_flags", 8'(Flags), 8'd0);
    chk("rst_strobes", 8'({PCWrite, IRWrite, MemWrite, RegWrite, LinkWrite}), 8'd0);
    nxt;
    reset = 1'b1;
    instr(4'hE, 2'b01, 6'b011001, 4'd1);
    fd;
    chk("ldr_regsrc", 8'(RegSrc), 8'd0);
    chk("ldr_immsrc", 8'(ImmSrc), 8'd1);
    nxt;
    chk("memadr_state", 8'(State), 8'd2);
    chk("memadr_add", 8'(ALUControl), 8'd0);
    MemReady = 1'b0;
    nxt;
    chk("memrd_state", 8'(State), 8'd3);
    chk("memrd_adrsrc", 8'(AdrSrc), 8'd1);
    reset = 1'b0;
    #1;
    chk("abort_state", 8'(State), 8'd0);
    chk("abort_regwrite", 8'(RegWrite), 8'd0);
    nxt;
    chk("abort_hold", 8'({State, RegWrite}), 8'd0);
    reset = 1'b1;
    fd;
    chk("decode_no_irw", 8'({IRWrite, PCWrite}), 8'b00);
    nxt;
    MemReady = 1'b0;
    nxt;
    for (int i = 0; i < 3; i++) begin
      chk("ldr_wait", 8'(State), 8'd3);
      nxt;
    end
    MemReady = 1'b1;
    #1;
    chk("ldr_wait_last", 8'(State), 8'd3);
    nxt;
    chk("memwb_state", 8'(State), 8'd4);
    chk("memwb_regwrite", 8'(RegWrite), 8'd1);
    chk("memwb_resultsrc", 8'(ResultSrc), 8'd1);
    chk("memwb_pcw_r1", 8'(PCWrite), 8'd0);
    Rd = 4'd15;
    #1;
    chk("memwb_pcw_r15", 8'(PCWrite), 8'd1);
    nxt;
    chk("ldr_done", 8'(State), 8'd0);
    instr(4'hE, 2'b00, 6'b000101, 4'd2);
    ALUFlags = 4'b0110;
    fd;
    nxt;
    chk("subs_exer", 8'(State), 8'd6);
    chk("subs_aluctl", 8'(ALUControl), 8'd1);
    chk("subs_srcb", 8'(ALUSrcB), 8'd0);
    nxt;
    chk("subs_aluwb", 8'(State), 8'd8);
    chk("subs_flags", 8'(Flags), 8'h6);
    chk("subs_regwrite", 8'(RegWrite), 8'd1);
    nxt;
    chk("subs_done", 8'(State), 8'd0);
    instr(4'h1, 2'b10, 6'b100000, 4'd0);
    fd;
    chk("b_regsrc", 8'(RegSrc), 8'b01);
    chk("b_immsrc", 8'(ImmSrc), 8'd2);
    nxt;
    chk("bne_z1_state", 8'(State), 8'd9);
    chk("bne_z1_pcw", 8'(PCWrite), 8'd0);
    chk("bne_z1_pcw_legacy", 8'(l_PCWrite), 8'd0);
    nxt;
    instr(4'hE, 2'b00, 6'b010101, 4'd0);
    ALUFlags = 4'b0000;
    fd;
    nxt;
    chk("cmp_aluctl", 8'(ALUControl), 8'd1);
    nxt;
    chk("cmp_nowrite", 8'(RegWrite), 8'd0);
    chk("cmp_flags", 8'(Flags), 8'h0);
    nxt;
    instr(4'h1, 2'b10, 6'b100000, 4'd0);
    fd;
    nxt;
    chk("bne_z0_pcw", 8'(PCWrite), 8'd1);
    chk("bne_z0_pcw_legacy", 8'(l_PCWrite), 8'd1);
    nxt;
    instr(4'hA, 2'b10, 6'b100000, 4'd0);
    fd;
    nxt;
    chk("bge_pcw", 8'(PCWrite), 8'd1);
    chk("bge_pcw_legacy", 8'(l_PCWrite), 8'd0);
    nxt;
    instr(4'h0, 2'b01, 6'b010000, 4'd3);
    fd;
    chk("str_regsrc", 8'(RegSrc), 8'b10);
    nxt;
    chk("str_sub_offset", 8'(ALUControl), 8'd1);
    MemReady = 1'b0;
    nxt;
    chk("streq_z0_state", 8'(State), 8'd5);
    chk("streq_z0_memwrite", 8'(MemWrite), 8'd0);
    nxt;
    chk("streq_z0_exit", 8'(State), 8'd0);
    exe(4'hE, 6'b010101, 4'b0100);
    chk("cmp_z1_flags", 8'(Flags), 8'h4);
    instr(4'h0, 2'b01, 6'b011000, 4'd3);
    fd;
    nxt;
    MemReady = 1'b0;
    nxt;
    chk("streq_w1", 8'({State, MemWrite}), {4'd5, 1'b1});
    nxt;
    chk("streq_w2", 8'({State, MemWrite}), {4'd5, 1'b1});
    MemReady = 1'b1;
    #1;
    chk("streq_w3", 8'({State, MemWrite}), {4'd5, 1'b1});
    nxt;
    chk("streq_done", 8'({State, MemWrite}), 8'd0);
    instr(4'hE, 2'b10, 6'b110000, 4'd0);
    fd;
    nxt;
    chk("bl_link_pcw", 8'({LinkWrite, PCWrite}), 8'b11);
    chk("bl_link_pcw_legacy", 8'({l_LinkWrite, l_PCWrite}), 8'b01);
    nxt;
    instr(4'hE, 2'b00, 6'b101001, 4'd0);
    ALUFlags = 4'b0011;
    fd;
    nxt;
    chk("adds_exei", 8'(State), 8'd7);
    chk("adds_srcb", 8'(ALUSrcB), 8'd1);
    chk("adds_aluctl", 8'(ALUControl), 8'd0);
    nxt;
    chk("adds_flags", 8'(Flags), 8'h3);
    nxt;
    exe(4'hE, 6'b000001, 4'b1011);
    chk("ands_flags", 8'(Flags), 8'hB);
    exe(4'hE, 6'b000001, 4'b1000);
    chk("ands_keep_cv", 8'(Flags), 8'hB);
    exe(4'hE, 6'b011001, 4'b0100);
    chk("orrs_keep_cv", 8'(Flags), 8'h7);
    exe(4'hE, 6'b001000, 4'b0000);
    chk("add_no_s", 8'(Flags), 8'h7);
    exe(4'h1, 6'b001001, 4'b0000);
    chk("adds_ne_skipped", 8'(Flags), 8'h7);
    instr(4'hE, 2'b11, 6'b000000, 4'd0);
    fd;
    nxt;
    chk("op11_nop", 8'(State), 8'd0);
    instr(4'hE, 2'b00, 6'b000110, 4'd0);
    fd;
    nxt;
    chk("bad_funct_nop", 8'(State), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/arm_multicycle_ctrl.md
Name: arm_multicycle_ctrl

Overview:
Multicycle control unit for the ARM-subset processor. It replaces the single-cycle combinational decoder with a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles. It holds an architectural NZCV flag register and checks all ARM condition codes (or the legacy EQ/NE/AL subset). It adds a memory-ready handshake so the datapath can share one unified memory with variable latency.

Parameters:
FULL_COND, 1, 1 = all 15 condition codes decoded; 0 = only EQ(0000), NE(0001), AL(1110) execute, every other code is treated as never-execute
BL_EN, 1, 1 = BL supported (writes R14); 0 = BL decoded as plain B

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
Cond  in  4  Instr[31:28]
Op  in  2  Instr[27:26]
Funct  in  6  Instr[25:20]
Rd  in  4  Instr[15:12]
ALUFlags  in  4  NZCV from the ALU, {N,Z,C,V}
MemReady  in  1  memory access completes this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address: 0 = PC, 1 = ALU result register
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register enable
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALU direct
ALUSrcA  out  1  0 = RD1, 1 = PC
ALUSrcB  out  2  00 RD2, 01 ExtImm, 10 constant 4
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
ImmSrc  out  2  00 8-bit DP, 01 12-bit mem, 10 24-bit branch
RegSrc  out  2  [0] Rn=R15, [1] Rm=Rd (STR)
RegWrite  out  1  register file write enable, already condition-gated
LinkWrite  out  1  write PC+4 to R14 (BL)
Flags  out  4  current flag register {N,Z,C,V}
State  out  4  FSM state code, debug only

Behaviour:
- Reset (reset=0, async): State=FETCH (0), Flags=0000, all strobes (PCWrite, IRWrite, MemWrite, RegWrite, LinkWrite) =0.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXER 6, EXEI 7, ALUWB 8, BRANCH 9.
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10. IRWrite and PCWrite are asserted only when MemReady=1. Stay in FETCH while MemReady=0. Go to DECODE when MemReady=1.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. ImmSrc=Op. RegSrc={Op==01 & ~Funct[0], Op==10}. Next state:
  - Op=01 -> MEMADR
  - Op=00 & Funct[5]=0 -> EXER
  - Op=00 & Funct[5]=1 -> EXEI
  - Op=10 -> BRANCH
  - Op=11 or unsupported Funct[4:1] -> FETCH (NOP)
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=00 (ADD if Funct[3]=U=1, SUB if U=0). Next: MEMRD if Funct[0]=1, else MEMWR.
- MEMRD: AdrSrc=1. Hold until MemReady=1, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondEx, then FETCH. If Rd=15 and CondEx, PCWrite=1.
- MEMWR: AdrSrc=1, MemWrite=CondEx. MemWrite is held until MemReady=1, then FETCH. If CondEx=0, go to FETCH immediately.
- EXER/EXEI: ALUSrcA=0, ALUSrcB=00/01. ALUControl decoded from Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, NoWrite). Next: ALUWB.
  - Flag update on the edge leaving EXE*, only if Funct[0]=S=1 and CondEx.
  - N and Z always take ALUFlags.
  - C and V take ALUFlags only for ADD/SUB/CMP; AND/ORR preserve them.
- ALUWB: ResultSrc=00, RegWrite=CondEx & ~NoWrite. If Rd=15, PCWrite=RegWrite. Then FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10. PCWrite=CondEx. LinkWrite=CondEx & Funct[4] & BL_EN. Then FETCH.
- CondEx is combinational from Cond and the registered Flags: EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V, HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V), AL 1, 1111 0.
- Flags change only at the EXE* exit, so CondEx is stable for the whole instruction.
- Latency per instruction: data-processing 4 cycles, branch 3 cycles, LDR 5 cycles, STR 4 cycles, each plus memory wait cycles.
- Reset asserted mid-instruction aborts it: no pending write completes, and the FSM returns to FETCH.

Test Plan:
- Reset low mid-MEMRD, then high -> State=0, Flags=0000, no RegWrite pulse; next FETCH with MemReady=1 -> IRWrite=1, PCWrite=1 for one cycle.
- SUBS (Op=00, Funct=000101, Cond=1110), ALUFlags=0110 -> states 0,1,6,8; Flags=0110 after EXER; RegWrite=1 in ALUWB.
- CMP then BNE with Flags Z=1 (Cond=0001) -> BRANCH with PCWrite=0; with Z=0 -> PCWrite=1. Repeat with FULL_COND=0, Cond=1010 (GE) -> PCWrite=0 regardless of flags.
- LDR with MemReady low 3 cycles in MEMRD -> State stays 3 for 3 cycles, then MEMWB with RegWrite=1; Rd=15 -> PCWrite=1 too.
- STREQ with Z=0 -> MemWrite never asserted, MEMWR->FETCH in 1 cycle; with Z=1 and MemReady delayed 2 cycles -> MemWrite held 3 cycles.
- BL (Funct=110000) -> LinkWrite=1, PCWrite=1; with BL_EN=0 -> LinkWrite=0. ANDS with ALUFlags=1011 from prior Flags=0011 -> Flags=1011 (N,Z from ALU; C,V preserved).
